d_pipe_reg: RTL and testbench

Parametrised, elastic chain of D-type register stages carrying a WIDTH-bit word with valid/ready flow control, bubble collapsing and synchronous flush. It is the general-purpose pipelining register for datapaths that previously used bare D flip-flops. It provides configurable width, depth and reset value, backpressure, an occupancy count and an optional complemented output.

---
 rtl/d_pipe_pkg.sv | 12 +
 rtl/d_pipe_stage.sv | 31 +++
 rtl/d_pipe_reg.sv | 94 +++++++++
 tb/tb_d_pipe_reg.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/d_pipe_pkg.sv
// Shared constants and helpers for the d_pipe_reg elastic register chain.
package d_pipe_pkg;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 3;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/d_pipe_stage.sv
// One elastic stage: a valid flag plus a data register that only changes on a load.
module d_pipe_stage
  import d_pipe_pkg::*;
#(
  parameter int unsigned          WIDTH   = DEF_WIDTH,
  parameter logic [WIDTH-1:0]     RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             adv,
  input  logic [WIDTH-1:0] din,
  output logic             v,
  output logic [WIDTH-1:0] data
);

  // Load wins over advance so a stage that hands off and refills stays valid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v    <= 1'b0;
      data <= RST_VAL;
    end else if (load) begin
      v    <= 1'b1;
      data <= din;
    end else if (adv) begin
      v    <= 1'b0;
    end
  end

endmodule

// File: rtl/d_pipe_reg.sv
// Elastic valid/ready register chain with bubble collapsing, flush and occupancy count.
// Optional complemented output qn is built when D_PIPE_QN_EN is defined.
module d_pipe_reg
  import d_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH   = DEF_WIDTH,
  parameter int unsigned      DEPTH   = DEF_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              d,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [occ_width(DEPTH)-1:0]   occupancy,
  output logic [WIDTH-1:0]              q
`ifdef D_PIPE_QN_EN
  ,
  output logic [WIDTH-1:0]              qn
`endif
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] load;
  logic [WIDTH-1:0] data [DEPTH];
  logic [WIDTH-1:0] din  [DEPTH];
  logic             acc;
  logic             xfer;

  // Ready chain resolved from the output stage back to the input stage.
  always_comb begin
    adv            = '0;
    load           = '0;
    adv[DEPTH-1]   = v[DEPTH-1] & out_ready;
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      adv[i] = v[i] & (~v[i+1] | adv[i+1]);
    end
    in_ready = ~flush & (~v[0] | adv[0]);
    load[0]  = in_valid & in_ready;
    for (int i = 1; i < int'(DEPTH); i++) begin
      load[i] = adv[i-1];
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    if (i == 0) begin : g_first
      assign din[i] = d;
    end else begin : g_rest
      assign din[i] = data[i-1];
    end

    d_pipe_stage #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .load  (load[i]),
      .adv   (adv[i]),
      .din   (din[i]),
      .v     (v[i]),
      .data  (data[i])
    );
  end

  assign acc  = in_valid & in_ready;
  assign xfer = v[DEPTH-1] & out_ready;

  // Occupancy tracks accepts minus output transfers.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      occupancy <= '0;
    end else if (acc && !xfer) begin
      occupancy <= occupancy + OCC_W'(1);
    end else if (!acc && xfer) begin
      occupancy <= occupancy - OCC_W'(1);
    end
  end

  assign out_valid = v[DEPTH-1];
  assign q         = data[DEPTH-1];

`ifdef D_PIPE_QN_EN
  assign qn = ~q;
`endif

endmodule

// File: tb/tb_d_pipe_reg.sv
// Randomised and directed bench for d_pipe_reg against a word-position queue model.
module tb_d_pipe_reg;
  import d_pipe_pkg::*;

  localparam int          W  = 8;
  localparam int          D  = 3;
  localparam logic [W-1:0] RV = 8'h00;

  logic                        clk;
  logic                        rst;
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [W-1:0]                d;
  logic                        out_valid;
  logic                        out_ready;
  logic [occ_width(D)-1:0]     occupancy;
  logic [W-1:0]                q;
`ifdef D_PIPE_QN_EN
  logic [W-1:0]                qn;
`endif

  d_pipe_reg #(
    .WIDTH   (W),
    .DEPTH   (D),
    .RST_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy),
    .q         (q)
`ifdef D_PIPE_QN_EN
    ,
    .qn        (qn)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model: each word in flight with its stage index; head is the oldest word.
  int           m_pos[$];
  logic [W-1:0] m_dat[$];
  logic [W-1:0] m_q = RV;
  bit           m_known = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, check outputs before the edge, then update the model.
  task automatic cycle(input bit iv, input logic [W-1:0] dv, input bit ordy,
                       input bit fl, input bit r);
    bit exp_rdy;
    bit exp_ov;
    int newp[$];
    bit pred_moved;
    int pred_old;
    @(negedge clk);
    in_valid  = iv;
    d         = dv;
    out_ready = ordy;
    flush     = fl;
    rst       = r;
    #1;
    exp_rdy = !fl && (m_pos.size() < D || ordy);
    exp_ov  = (m_pos.size() > 0) && (m_pos[0] == D - 1);
    if (m_known) begin
      chk("in_ready",  32'(in_ready),  32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("q",         32'(q),         32'(m_q));
      chk("occupancy", 32'(occupancy), 32'(m_pos.size()));
`ifdef D_PIPE_QN_EN
      chk("qn",        32'(qn),        32'(~m_q));
`endif
    end
    @(posedge clk);
    if (r || fl) begin
      m_pos.delete();
      m_dat.delete();
      if (r || m_known) m_q = RV;
      if (r) m_known = 1'b1;
    end else begin
      // A word moves one stage on unless the word ahead sits right in front and stays.
      pred_moved = 1'b0;
      pred_old   = -1;
      for (int k = 0; k < m_pos.size(); k++) begin
        int p;
        int np;
        p = m_pos[k];
        if (k == 0) np = (p == D - 1) ? (ordy ? D : p) : p + 1;
        else        np = (pred_moved || (p + 1 != pred_old)) ? p + 1 : p;
        pred_moved = (np != p);
        pred_old   = p;
        newp.push_back(np);
        if (np == D - 1 && np != p) m_q = m_dat[k];
      end
      if (newp.size() > 0 && newp[0] == D) begin
        void'(newp.pop_front());
        void'(m_dat.pop_front());
      end
      m_pos = newp;
      if (iv && exp_rdy) begin
        m_pos.push_back(0);
        m_dat.push_back(dv);
        if (D == 1) m_q = dv;
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; d = '0;

    // Reset held two cycles with a word offered.
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Back-to-back streaming with the sink always ready.
    for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Bubble collapse under backpressure, then release.
    cycle(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h44, 1'b1, 1'b0, 1'b0);

    // Full with simultaneous accept and output transfer.
    for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h60 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush at occupancy 2 with a word offered that must be dropped.
    cycle(1'b1, 8'h71, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h72, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) != 0,
            $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
